ysyx_25040111_arbiter: RTL and testbench
========================================

YSYX_25040111_ARBITER -- requirements
Module: ysyx_25040111_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width of R/W channels.
REQ-003 The block SHALL have parameter TMO_CYC, default 4096, cycles a granted transaction may stay open before timeout is flagged.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 m0_ar{valid,ready,addr,size}  in/out/in/in  1/1/ADDR_W/3  IFU read-address channel (master 0, read-only).
REQ-007 m0_r{valid,ready,data,resp,last}  out/in/out/out/out  1/1/DATA_W/2/1  IFU read-data channel.
REQ-008 m1_ar{valid,ready,addr,size}  in/out/in/in  1/1/ADDR_W/3  LSU read-address channel (master 1).
REQ-009 m1_r{valid,ready,data,resp,last}  out/in/out/out/out  1/1/DATA_W/2/1  LSU read-data channel.
REQ-010 m1_aw{valid,ready,addr,size}, m1_w{valid,ready,data,strb,last}, m1_b{valid,ready,resp}  mixed  per AXI4  LSU write channels.
REQ-011 s_* (ar, r, aw, w, b)  mirrored directions  as above  single downstream AXI4 master port (io_master); s_arid/s_awid=0, s_arlen/s_awlen=0, s_arburst/s_awburst=0 constant.
REQ-012 tmo  out  1  one-cycle pulse when a granted transaction exceeds TMO_CYC.

Function
REQ-013 The block SHALL implement states IDLE, RD0 (IFU read), RD1 (LSU read), WR1 (LSU write), held in a registered state variable.
REQ-014 From IDLE, priority SHALL be m1_arvalid -> RD1, else m1_awvalid -> WR1, else m0_arvalid -> RD0, else stay IDLE.
REQ-015 Grant SHALL take effect the cycle after the request is sampled in IDLE; in IDLE all s_*valid=0 and all m*_*ready=0.
REQ-016 In RD0/RD1 the granted master's AR and R channels SHALL be connected combinationally to s_ar/s_r; all other masters see ready=0, valid=0, data=0, resp=0.
REQ-017 In WR1, m1 AW, W, B SHALL connect combinationally to s_aw, s_w, s_b; s_ar*valid and s_rready=0.
REQ-018 RD0/RD1 SHALL return to IDLE on the cycle after s_rvalid & s_rready & s_rlast.
REQ-019 WR1 SHALL return to IDLE on the cycle after s_bvalid & s_bready; AW and W completing in either order or same cycle SHALL NOT end the state early.
REQ-020 A request arriving while another master is granted SHALL be held pending (ready=0) with no loss; requester must keep valid asserted per AXI.
REQ-021 After returning to IDLE, arbitration per REQ-014 SHALL occur again; back-to-back grants therefore have one IDLE cycle between them.
REQ-022 rresp/bresp SHALL be passed through unmodified; the arbiter SHALL NOT alter or absorb error responses.
REQ-023 A cycle counter SHALL clear on entering any non-IDLE state, increment each granted cycle, saturate at TMO_CYC, and pulse tmo exactly once on reaching TMO_CYC; state SHALL remain granted.
REQ-024 Combinational paths SHALL exist only through the data-path mux; grant select SHALL depend on registered state only (no valid->ready combinational loop through arbitration).

Reset
REQ-025 While rst=1, state SHALL be IDLE, counter 0, tmo 0, all s_*valid and m*_*ready outputs 0.
REQ-026 Reset asserted mid-transaction SHALL abort immediately to IDLE; downstream cleanup is the system's responsibility.
REQ-027 First arbitration SHALL occur on the first posedge after rst deasserts.

Structure
REQ-028 State encodings (IDLE=2'd0, RD0=2'd1, RD1=2'd2, WR1=2'd3) and AXI resp codes SHALL live in the shared include header ysyx_25040111_inc.vh.
REQ-029 Channel multiplexing SHALL reuse ysyx_25040111_MuxKey keyed on state; no further sub-module is required.

Verification
REQ-030 m0_arvalid alone, addr 0x3000_0000 -> s_arvalid high one cycle later, addr forwarded, m0_rdata returned, state back to IDLE after rlast.
REQ-031 m0_arvalid and m1_arvalid same cycle -> m1 granted first (RD1), m0 served after one IDLE cycle; m0_arready stays 0 meanwhile.
REQ-032 m1 write, wdata 0xDEADBEEF, strb 4'b0011, slave gives wready before awready -> single s_w handshake, m1_bvalid forwarded, WR1 exits only after B.
REQ-033 Slave returns rresp=2'b10 -> m1_rresp=2'b10 unchanged, normal return to IDLE.
REQ-034 Slave never asserts rvalid, TMO_CYC=16 -> tmo pulses once 16 cycles after grant, state remains RD0.
REQ-035 rst asserted during WR1 after AW handshake -> all outputs 0 same cycle, state IDLE, new m0 read granted after rst release.

Source files
------------

// File: rtl/ysyx_25040111_arbiter_pkg.sv
// Shared constants for the IFU/LSU AXI arbiter: FSM state encodings, AXI
// response codes and the fixed ID/burst values driven on the downstream port.
package ysyx_25040111_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD0  = 2'd1;
  localparam logic [1:0] ST_RD1  = 2'd2;
  localparam logic [1:0] ST_WR1  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int         AXI_ID_W   = 4;
  localparam logic [3:0] AXI_ID     = 4'd0;
  localparam logic [7:0] AXI_LEN    = 8'd0;
  localparam logic [1:0] AXI_BURST  = 2'd0;

endpackage

// File: rtl/ysyx_25040111_arbiter_muxkey.sv
// Generic key-selected multiplexer: lut holds NR_KEY {key, data} pairs packed
// with entry 0 in the least significant bits; unmatched keys yield default_out.
module ysyx_25040111_MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_W = KEY_LEN + DATA_LEN;

  always_comb begin
    out = default_out;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_W+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_W +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/ysyx_25040111_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one AXI4 slave arbiter.
// Grant is a registered FSM state; all channel steering is a state-keyed mux.
module ysyx_25040111_arbiter
  import ysyx_25040111_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic [2:0]            m0_arsize,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic [2:0]            m1_arsize,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic [2:0]            m1_awsize,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wlast,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  output logic [1:0]            m1_bresp,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [2:0]            s_arsize,
  output logic [AXI_ID_W-1:0]   s_arid,
  output logic [7:0]            s_arlen,
  output logic [1:0]            s_arburst,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [2:0]            s_awsize,
  output logic [AXI_ID_W-1:0]   s_awid,
  output logic [7:0]            s_awlen,
  output logic [1:0]            s_awburst,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wlast,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp,
  output logic                  tmo
);

  localparam int AR_W  = 1 + ADDR_W + 3;
  localparam int R_W   = 1 + 1 + DATA_W + 2 + 1;
  localparam int WO_W  = 1 + ADDR_W + 3 + 1 + DATA_W + DATA_W/8 + 1 + 1;
  localparam int WI_W  = 1 + 1 + 1 + 2;
  localparam int CW    = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TMO_CYC);
  localparam logic [CW-1:0] CNT_PRE = CW'(TMO_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [AR_W-1:0] s_ar_bus;
  logic [R_W-1:0]  s_r_bus, m0_r_bus, m1_r_bus;
  logic [WO_W-1:0] s_w_bus;
  logic [WI_W-1:0] m1_wr_bus;

  assign s_arid    = AXI_ID;
  assign s_arlen   = AXI_LEN;
  assign s_arburst = AXI_BURST;
  assign s_awid    = AXI_ID;
  assign s_awlen   = AXI_LEN;
  assign s_awburst = AXI_BURST;

  // Every select below is state_q alone, so no valid->ready path crosses arbitration.
  ysyx_25040111_MuxKey #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(AR_W)) u_ar_mux (
    .out         (s_ar_bus),
    .key         (state_q),
    .default_out ({AR_W{1'b0}}),
    .lut         ({ST_RD1, m1_arvalid, m1_araddr, m1_arsize,
                   ST_RD0, m0_arvalid, m0_araddr, m0_arsize})
  );
  assign {s_arvalid, s_araddr, s_arsize} = s_ar_bus;

  ysyx_25040111_MuxKey #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(1)) u_rready_mux (
    .out         (s_rready),
    .key         (state_q),
    .default_out (1'b0),
    .lut         ({ST_RD1, m1_rready, ST_RD0, m0_rready})
  );

  assign s_r_bus = {s_arready, s_rvalid, s_rdata, s_rresp, s_rlast};

  ysyx_25040111_MuxKey #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(R_W)) u_m0_r_mux (
    .out         (m0_r_bus),
    .key         (state_q),
    .default_out ({R_W{1'b0}}),
    .lut         ({ST_RD0, s_r_bus})
  );
  assign {m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_rlast} = m0_r_bus;

  ysyx_25040111_MuxKey #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(R_W)) u_m1_r_mux (
    .out         (m1_r_bus),
    .key         (state_q),
    .default_out ({R_W{1'b0}}),
    .lut         ({ST_RD1, s_r_bus})
  );
  assign {m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_rlast} = m1_r_bus;

  ysyx_25040111_MuxKey #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(WO_W)) u_w_mux (
    .out         (s_w_bus),
    .key         (state_q),
    .default_out ({WO_W{1'b0}}),
    .lut         ({ST_WR1, m1_awvalid, m1_awaddr, m1_awsize,
                   m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready})
  );
  assign {s_awvalid, s_awaddr, s_awsize,
          s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready} = s_w_bus;

  ysyx_25040111_MuxKey #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(WI_W)) u_b_mux (
    .out         (m1_wr_bus),
    .key         (state_q),
    .default_out ({WI_W{1'b0}}),
    .lut         ({ST_WR1, s_awready, s_wready, s_bvalid, s_bresp})
  );
  assign {m1_awready, m1_wready, m1_bvalid, m1_bresp} = m1_wr_bus;

  // Writes end only on the B handshake, whatever order AW and W completed in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m1_arvalid)      state_d = ST_RD1;
        else if (m1_awvalid) state_d = ST_WR1;
        else if (m0_arvalid) state_d = ST_RD0;
      end
      ST_RD0, ST_RD1: begin
        if (s_rvalid && s_rready && s_rlast) state_d = ST_IDLE;
      end
      default: begin
        if (s_bvalid && s_bready) state_d = ST_IDLE;
      end
    endcase
  end

  // Saturating at TMO_CYC means the one-before-max match happens once per grant.
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if ((state_q != ST_IDLE) && (state_d == state_q) && (cnt_q == CNT_PRE)) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign tmo = tmo_q;

endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// Directed bench for the IFU/LSU arbiter: the bench plays the slave by hand and
// checks grant order, pass-through, write completion, timeout and reset abort.
module tb_ysyx_25040111_arbiter;
  import ysyx_25040111_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk, rst;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [AW-1:0] m0_araddr;
  logic [2:0]    m0_arsize;
  logic [DW-1:0] m0_rdata;
  logic [1:0]    m0_rresp;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [AW-1:0] m1_araddr, m1_awaddr;
  logic [2:0]    m1_arsize, m1_awsize;
  logic [DW-1:0] m1_rdata, m1_wdata;
  logic [1:0]    m1_rresp, m1_bresp;
  logic          m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
  logic [3:0]    m1_wstrb;
  logic          m1_bvalid, m1_bready;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [2:0]    s_arsize, s_awsize;
  logic [3:0]    s_arid, s_awid;
  logic [7:0]    s_arlen, s_awlen;
  logic [1:0]    s_arburst, s_awburst, s_rresp, s_bresp;
  logic [DW-1:0] s_rdata, s_wdata;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [3:0]    s_wstrb;
  logic          s_bvalid, s_bready;
  logic          tmo;

  int checks = 0;
  int errors = 0;

  ysyx_25040111_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .tmo(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the given number of clock edges, then settle just past the edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_arvalid = 0; m0_araddr = '0; m0_arsize = 3'd2; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arsize = 3'd2; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awsize = 3'd2;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;

    // Reset: request already pending must stay invisible downstream
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; s_arready = 1;
    applyStimulus(2);
    checkOutput("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    checkOutput("rst_m0_arready", 64'(m0_arready), 64'd0);
    checkOutput("rst_tmo", 64'(tmo), 64'd0);
    s_arready = 0;
    rst = 1'b0;

    // IFU read alone
    applyStimulus(1);
    checkOutput("rd0_state", 64'(dut.state_q), 64'(ST_RD0));
    checkOutput("rd0_s_arvalid", 64'(s_arvalid), 64'd1);
    checkOutput("rd0_s_araddr", 64'(s_araddr), 64'h3000_0000);
    checkOutput("rd0_consts", 64'({s_arid, s_arlen, s_arburst}), 64'd0);
    s_arready = 1; #1;
    checkOutput("rd0_m0_arready", 64'(m0_arready), 64'd1);
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rresp = RESP_OKAY; s_rlast = 1; m0_rready = 1; #1;
    checkOutput("rd0_m0_rvalid", 64'(m0_rvalid), 64'd1);
    checkOutput("rd0_m0_rdata", 64'(m0_rdata), 64'h1234_5678);
    checkOutput("rd0_m1_rvalid", 64'(m1_rvalid), 64'd0);
    checkOutput("rd0_s_rready", 64'(s_rready), 64'd1);
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    checkOutput("rd0_back_idle", 64'(dut.state_q), 64'(ST_IDLE));

    // Simultaneous reads: LSU first, IFU held off, SLVERR passes through
    m0_arvalid = 1; m0_araddr = 32'h3000_0040;
    m1_arvalid = 1; m1_araddr = 32'h8000_0100;
    applyStimulus(1);
    checkOutput("pri_state", 64'(dut.state_q), 64'(ST_RD1));
    checkOutput("pri_s_araddr", 64'(s_araddr), 64'h8000_0100);
    s_arready = 1; #1;
    checkOutput("pri_m1_arready", 64'(m1_arready), 64'd1);
    checkOutput("pri_m0_arready", 64'(m0_arready), 64'd0);
    applyStimulus(1);
    m1_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hCAFE_0001; s_rresp = RESP_SLVERR; s_rlast = 1; m1_rready = 1; #1;
    checkOutput("err_m1_rresp", 64'(m1_rresp), 64'(RESP_SLVERR));
    checkOutput("err_m1_rdata", 64'(m1_rdata), 64'hCAFE_0001);
    checkOutput("pri_m0_rdata", 64'(m0_rdata), 64'd0);
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; s_rresp = RESP_OKAY; m1_rready = 0;
    s_arready = 1; #1;
    checkOutput("gap_state", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("gap_m0_arready", 64'(m0_arready), 64'd0);
    checkOutput("gap_s_arvalid", 64'(s_arvalid), 64'd0);
    applyStimulus(1);
    checkOutput("pend_state", 64'(dut.state_q), 64'(ST_RD0));
    checkOutput("pend_s_araddr", 64'(s_araddr), 64'h3000_0040);
    checkOutput("pend_m0_arready", 64'(m0_arready), 64'd1);
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rlast = 1; m0_rready = 1;
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    checkOutput("pend_back_idle", 64'(dut.state_q), 64'(ST_IDLE));

    // LSU write, W accepted before AW
    m1_awvalid = 1; m1_awaddr = 32'h8000_0010;
    m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011; m1_wlast = 1; m1_bready = 1;
    applyStimulus(1);
    checkOutput("wr_state", 64'(dut.state_q), 64'(ST_WR1));
    checkOutput("wr_s_awaddr", 64'(s_awaddr), 64'h8000_0010);
    checkOutput("wr_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    checkOutput("wr_s_wstrb", 64'(s_wstrb), 64'h3);
    checkOutput("wr_s_arvalid", 64'(s_arvalid), 64'd0);
    checkOutput("wr_s_rready", 64'(s_rready), 64'd0);
    s_wready = 1; #1;
    checkOutput("wr_m1_wready", 64'(m1_wready), 64'd1);
    checkOutput("wr_m1_awready", 64'(m1_awready), 64'd0);
    applyStimulus(1);
    m1_wvalid = 0; s_wready = 0; s_awready = 1; #1;
    checkOutput("wr_s_wvalid_once", 64'(s_wvalid), 64'd0);
    checkOutput("wr_m1_awready2", 64'(m1_awready), 64'd1);
    applyStimulus(1);
    m1_awvalid = 0; s_awready = 0;
    checkOutput("wr_no_early_exit", 64'(dut.state_q), 64'(ST_WR1));
    s_bvalid = 1; s_bresp = RESP_OKAY; #1;
    checkOutput("wr_m1_bvalid", 64'(m1_bvalid), 64'd1);
    checkOutput("wr_s_bready", 64'(s_bready), 64'd1);
    applyStimulus(1);
    s_bvalid = 0; m1_bready = 0;
    checkOutput("wr_back_idle", 64'(dut.state_q), 64'(ST_IDLE));

    // Slave never returns data: single tmo pulse 16 cycles after grant
    m0_arvalid = 1; m0_araddr = 32'h3000_0080;
    applyStimulus(1);
    checkOutput("tmo_grant_state", 64'(dut.state_q), 64'(ST_RD0));
    checkOutput("tmo_k0", 64'(tmo), 64'd0);
    s_arready = 1;
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(1);
      m0_arvalid = 0; s_arready = 0;
      checkOutput($sformatf("tmo_k%0d", k), 64'(tmo), 64'(k == 16));
    end
    checkOutput("tmo_state_held", 64'(dut.state_q), 64'(ST_RD0));
    s_rvalid = 1; s_rlast = 1; m0_rready = 1;
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;

    // Reset mid-write after the AW handshake
    m1_awvalid = 1; m1_awaddr = 32'h8000_0020; m1_wvalid = 1; m1_wlast = 1; m1_bready = 1;
    applyStimulus(1);
    s_awready = 1;
    applyStimulus(1);
    m1_awvalid = 0; s_awready = 0; s_wready = 1;
    checkOutput("abort_pre_state", 64'(dut.state_q), 64'(ST_WR1));
    m0_arvalid = 1; m0_araddr = 32'h3000_0004;
    rst = 1'b1; #1;
    checkOutput("abort_state", 64'(dut.state_q), 64'(ST_IDLE));
    checkOutput("abort_s_wvalid", 64'(s_wvalid), 64'd0);
    checkOutput("abort_m1_wready", 64'(m1_wready), 64'd0);
    checkOutput("abort_s_bready", 64'(s_bready), 64'd0);
    applyStimulus(1);
    m1_wvalid = 0; m1_bready = 0; s_wready = 0;
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("abort_regrant", 64'(dut.state_q), 64'(ST_RD0));
    checkOutput("abort_s_araddr", 64'(s_araddr), 64'h3000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
